// File: rtl/stream_normalizer.sv
// Packs an AXI4-Stream with partial, LSB-contiguous tkeep into full beats; only the tlast beat may be partial.
// Optional macro STREAM_NORMALIZER_KEEP_CHECK_EN adds a sticky non-contiguous-tkeep flag with bit-order packing.
module stream_normalizer #(
  parameter int DATA_BYTES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*DATA_BYTES-1:0] data_in_tdata,
  input  logic [DATA_BYTES-1:0]   data_in_tkeep,
  input  logic                    data_in_tlast,
  input  logic                    data_in_tvalid,
  output logic                    data_in_tready,
  output logic [8*DATA_BYTES-1:0] data_out_tdata,
  output logic [DATA_BYTES-1:0]   data_out_tkeep,
  output logic                    data_out_tlast,
  output logic                    data_out_tvalid,
  input  logic                    data_out_tready,
  output logic                    keep_err
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int RW  = 8 * (DATA_BYTES - 1);
  localparam int RCW = $clog2(DATA_BYTES);
  localparam int CW  = $clog2(2 * DATA_BYTES);
  localparam logic [CW-1:0] FULL_C = CW'(DATA_BYTES);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  function automatic logic [CW-1:0] popcount(input logic [DATA_BYTES-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      n = n + {{(CW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  function automatic logic [DATA_BYTES-1:0] keep_mask(input logic [CW-1:0] n);
    logic [DATA_BYTES-1:0] m;
    for (int i = 0; i < DATA_BYTES; i++) begin
      m[i] = (CW'(i) < n);
    end
    return m;
  endfunction

  state_t                state_r, state_nxt_s;
  logic [RW-1:0]         res_r, res_nxt_s;
  logic [RCW-1:0]        res_cnt_r, res_cnt_nxt_s;
  logic                  o_valid_r, o_last_r;
  logic [DW-1:0]         o_data_r;
  logic [DATA_BYTES-1:0] o_keep_r;

  logic                  out_free_s, accept_s;
  logic [CW-1:0]         k_s, c_s;
  logic [DW-1:0]         in_data_s;
  logic [DW+RW-1:0]      comb_s;
  logic                  emit_s, emit_last_s;
  logic [DW-1:0]         emit_data_s;
  logic [DATA_BYTES-1:0] emit_keep_s;

  assign out_free_s     = !o_valid_r || data_out_tready;
  assign data_in_tready = out_free_s && (state_r == ST_RUN);
  assign accept_s       = data_in_tvalid && data_in_tready;
  assign k_s            = popcount(data_in_tkeep);
  assign c_s            = CW'(res_cnt_r) + k_s;

`ifdef STREAM_NORMALIZER_KEEP_CHECK_EN
  // Compact kept bytes toward byte 0 in bit order, so holes in tkeep are squeezed out.
  always_comb begin
    int idx;
    in_data_s = '0;
    idx       = 0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      in_data_s[idx*8 +: 8] = data_in_tkeep[j] ? data_in_tdata[j*8 +: 8] : in_data_s[idx*8 +: 8];
      idx = idx + (data_in_tkeep[j] ? 1 : 0);
    end
  end
`else
  // Zero unkept bytes so the combined vector is clean above its byte count.
  always_comb begin
    in_data_s = '0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      in_data_s[j*8 +: 8] = data_in_tkeep[j] ? data_in_tdata[j*8 +: 8] : 8'h00;
    end
  end
`endif

  // New bytes land directly above the residual bytes.
  assign comb_s = {{DW{1'b0}}, res_r} | ({{RW{1'b0}}, in_data_s} << {res_cnt_r, 3'b000});

  // Next-state, residual update and emitted beat selection.
  always_comb begin
    state_nxt_s   = state_r;
    res_nxt_s     = res_r;
    res_cnt_nxt_s = res_cnt_r;
    emit_s        = 1'b0;
    emit_data_s   = '0;
    emit_keep_s   = '0;
    emit_last_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (accept_s) begin
          if (data_in_tlast && (c_s > FULL_C)) begin
            emit_s        = 1'b1;
            emit_data_s   = comb_s[DW-1:0];
            emit_keep_s   = '1;
            res_nxt_s     = comb_s[DW +: RW];
            res_cnt_nxt_s = RCW'(c_s - FULL_C);
            state_nxt_s   = ST_FLUSH;
          end else if (data_in_tlast) begin
            emit_s        = 1'b1;
            emit_data_s   = comb_s[DW-1:0];
            emit_keep_s   = keep_mask(c_s);
            emit_last_s   = 1'b1;
            res_nxt_s     = '0;
            res_cnt_nxt_s = '0;
          end else if (c_s >= FULL_C) begin
            emit_s        = 1'b1;
            emit_data_s   = comb_s[DW-1:0];
            emit_keep_s   = '1;
            res_nxt_s     = comb_s[DW +: RW];
            res_cnt_nxt_s = RCW'(c_s - FULL_C);
          end else begin
            res_nxt_s     = comb_s[RW-1:0];
            res_cnt_nxt_s = RCW'(c_s);
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (out_free_s) begin
          emit_s        = 1'b1;
          emit_data_s   = {8'h00, res_r};
          emit_keep_s   = keep_mask(CW'(res_cnt_r));
          emit_last_s   = 1'b1;
          res_nxt_s     = '0;
          res_cnt_nxt_s = '0;
          state_nxt_s   = ST_RUN;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State and residual registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      res_r     <= '0;
      res_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      res_r     <= res_nxt_s;
      res_cnt_r <= res_cnt_nxt_s;
    end
  end

  // Output register; it only advances when the downstream can take a beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_r <= 1'b0;
      o_data_r  <= '0;
      o_keep_r  <= '0;
      o_last_r  <= 1'b0;
    end else if (out_free_s) begin
      o_valid_r <= emit_s;
      if (emit_s) begin
        o_data_r <= emit_data_s;
        o_keep_r <= emit_keep_s;
        o_last_r <= emit_last_s;
      end
    end
  end

  assign data_out_tvalid = o_valid_r;
  assign data_out_tdata  = o_data_r;
  assign data_out_tkeep  = o_keep_r;
  assign data_out_tlast  = o_last_r;

`ifdef STREAM_NORMALIZER_KEEP_CHECK_EN
  logic keep_err_r;

  // Contiguous-from-bit-0 masks satisfy tkeep & (tkeep+1) == 0, including all-0s and all-1s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keep_err_r <= 1'b0;
    end else if (accept_s &&
                 ((data_in_tkeep & (data_in_tkeep + {{(DATA_BYTES-1){1'b0}}, 1'b1})) != '0)) begin
      keep_err_r <= 1'b1;
    end
  end

  assign keep_err = keep_err_r;
`else
  assign keep_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_normalizer.sv
// Scoreboard bench for stream_normalizer (DATA_BYTES=64): directed packing/flush/empty/reset cases plus random backpressure.
module tb_stream_normalizer;
  localparam int DB = 64;
  localparam int DW = 8 * DB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_tdata;
  logic [DB-1:0] in_tkeep;
  logic          in_tlast, in_tvalid, in_tready;
  logic [DW-1:0] out_tdata;
  logic [DB-1:0] out_tkeep;
  logic          out_tlast, out_tvalid, out_tready;
  logic          keep_err;

  stream_normalizer #(.DATA_BYTES(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_tdata(in_tdata), .data_in_tkeep(in_tkeep), .data_in_tlast(in_tlast),
    .data_in_tvalid(in_tvalid), .data_in_tready(in_tready),
    .data_out_tdata(out_tdata), .data_out_tkeep(out_tkeep), .data_out_tlast(out_tlast),
    .data_out_tvalid(out_tvalid), .data_out_tready(out_tready),
    .keep_err(keep_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [DB-1:0] k;
    logic          l;
  } beat_t;

  beat_t       exp_q[$];
  logic [7:0]  mq[$];
  int          tests = 0;
  int          fails = 0;
  bit          rand_rdy = 1'b0;

  function automatic logic [7:0] pat(input int t, input int j);
    return 8'((t * 64 + j) & 255);
  endfunction

  function automatic logic [DW-1:0] pbeat(input int t);
    logic [DW-1:0] d;
    for (int j = 0; j < DB; j++) d[j*8 +: 8] = pat(t, j);
    return d;
  endfunction

  function automatic logic [DB-1:0] kmask(input int n);
    logic [DB-1:0] m;
    for (int i = 0; i < DB; i++) m[i] = (i < n);
    return m;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic emit_model(input int n, input logic l);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[i*8 +: 8] = mq.pop_front();
    push_exp(d, kmask(n), l);
  endtask

  // Reference: bytes accumulate; a non-last beat releases one full beat when 64 are held,
  // a last beat releases a full beat if more than 64 are held, then everything left as the last beat.
  task automatic model_beat(input logic [DW-1:0] d, input int k, input logic l);
    for (int j = 0; j < k; j++) mq.push_back(d[j*8 +: 8]);
    if (!l) begin
      if (mq.size() >= DB) emit_model(DB, 1'b0);
    end else begin
      if (mq.size() > DB) emit_model(DB, 1'b0);
      emit_model(mq.size(), 1'b1);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
    int n;
    in_tdata = d; in_tkeep = k; in_tlast = l; in_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_tready) break;
      n++;
      if (n > 1000) begin
        tests++; fails++;
        $display("FAIL send_timeout: tready low for %0d cycles, expected accept", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check("drain", DW'(exp_q.size()), DW'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare each accepted output beat and hold stability while stalled.
  logic [DW-1:0] hd;
  logic [DB-1:0] hk;
  logic          hl;
  bit            stall = 1'b0;
  beat_t         e;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", DW'(out_tvalid), DW'(1'b1));
        check("stall_data", out_tdata, hd);
        check("stall_keep", DW'(out_tkeep), DW'(hk));
        check("stall_last", DW'(out_tlast), DW'(hl));
      end
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got keep %h last %0d, expected no beat", out_tkeep, out_tlast);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_tdata, e.d);
          check("out_keep", DW'(out_tkeep), DW'(e.k));
          check("out_last", DW'(out_tlast), DW'(e.l));
        end
      end
      stall = out_tvalid && !out_tready;
      hd = out_tdata; hk = out_tkeep; hl = out_tlast;
    end
  end

  // Random downstream backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_tready = 1'($urandom_range(0, 1));
  end

  logic [DW-1:0] d;
  int            nb, k;

  initial begin
    rst_n = 1'b0; in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0;
    out_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", DW'(out_tvalid), DW'(1'b0));
    check("rst_tlast", DW'(out_tlast), DW'(1'b0));
    check("rst_tkeep", DW'(out_tkeep), DW'(0));
    check("rst_keep_err", DW'(keep_err), DW'(1'b0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_tready", DW'(in_tready), DW'(1'b1));

    // 1: full beats pass through with one-cycle latency
    for (int t = 0; t < 3; t++) push_exp(pbeat(t), '1, (t == 2));
    send(pbeat(0), '1, 1'b0);
    check("latency_valid", DW'(out_tvalid), DW'(1'b1));
    send(pbeat(1), '1, 1'b0);
    send(pbeat(2), '1, 1'b1);
    wait_drain();

    // 2: 40 + 40 + 10(last) -> 64 full, then 26 last
    d = '0;
    for (int i = 0; i < DB; i++) d[i*8 +: 8] = (i < 40) ? pat(0, i) : pat(1, i - 40);
    push_exp(d, '1, 1'b0);
    d = '0;
    for (int i = 0; i < 26; i++) d[i*8 +: 8] = (i < 16) ? pat(1, 24 + i) : pat(2, i - 16);
    push_exp(d, 64'h0000_0000_03FF_FFFF, 1'b1);
    send(pbeat(0), kmask(40), 1'b0);
    send(pbeat(1), kmask(40), 1'b0);
    send(pbeat(2), kmask(10), 1'b1);
    wait_drain();

    // 3: 60 + 60(last) -> 64 full, FLUSH bubble, 56 last
    d = '0;
    for (int i = 0; i < DB; i++) d[i*8 +: 8] = (i < 60) ? pat(0, i) : pat(1, i - 60);
    push_exp(d, '1, 1'b0);
    d = '0;
    for (int i = 0; i < 56; i++) d[i*8 +: 8] = pat(1, 4 + i);
    push_exp(d, kmask(56), 1'b1);
    send(pbeat(0), kmask(60), 1'b0);
    send(pbeat(1), kmask(60), 1'b1);
    check("flush_tready_low", DW'(in_tready), DW'(1'b0));
    @(posedge clk);
    #1;
    check("flush_tready_back", DW'(in_tready), DW'(1'b1));
    wait_drain();

    // 4: empty stream end, then a k=0 non-last beat that must produce nothing
    push_exp('0, '0, 1'b1);
    send(pbeat(0), '0, 1'b1);
    wait_drain();
    send(pbeat(1), '0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("k0_no_output", DW'(exp_q.size()), DW'(0));
    d = '0;
    for (int i = 0; i < 5; i++) d[i*8 +: 8] = pat(3, i);
    push_exp(d, 64'h0000_0000_0000_001F, 1'b1);
    send(pbeat(3), kmask(5), 1'b1);
    wait_drain();

`ifdef STREAM_NORMALIZER_KEEP_CHECK_EN
    // 6a: non-contiguous keep sets the sticky flag; bytes 0 and 2 pack to bytes 0 and 1
    check("keep_err_clear", DW'(keep_err), DW'(1'b0));
    d = '0;
    d[7:0]  = pat(0, 0);
    d[15:8] = pat(0, 2);
    push_exp(d, 64'h0000_0000_0000_0003, 1'b1);
    send(pbeat(0), 64'h0000_0000_0000_0005, 1'b1);
    check("keep_err_set", DW'(keep_err), DW'(1'b1));
    wait_drain();
    check("keep_err_sticky", DW'(keep_err), DW'(1'b1));
`endif

    // 6b: reset mid-stream drops residual and a stalled output beat
    out_tready = 1'b0;
    send(pbeat(0), kmask(40), 1'b0);
    send(pbeat(1), kmask(40), 1'b0);
    check("stalled_valid", DW'(out_tvalid), DW'(1'b1));
    rst_n = 1'b0;
    exp_q.delete();
    mq.delete();
    #1;
    check("midrst_tvalid", DW'(out_tvalid), DW'(1'b0));
    check("midrst_tkeep", DW'(out_tkeep), DW'(0));
    check("midrst_keep_err", DW'(keep_err), DW'(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_tready = 1'b1;
    @(posedge clk);
    #1;
    d = '0;
    for (int i = 0; i < 10; i++) d[i*8 +: 8] = pat(2, i);
    push_exp(d, 64'h0000_0000_0000_03FF, 1'b1);
    send(pbeat(2), kmask(10), 1'b1);
    wait_drain();

    // 5: random contiguous-k streams under 50% backpressure
    rand_rdy = 1'b1;
    for (int s = 0; s < 1000; s++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        k = ($urandom_range(0, 3) == 0) ? DB : $urandom_range(0, DB);
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        model_beat(d, k, (b == nb - 1));
        send(d, kmask(k), (b == nb - 1));
      end
    end
    wait_drain();
    rand_rdy = 1'b0;
    out_tready = 1'b1;

`ifndef STREAM_NORMALIZER_KEEP_CHECK_EN
    check("keep_err_tied", DW'(keep_err), DW'(1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
